// File: rtl/irq_ctl_if.sv
// irq_ctl_if: bus between the interrupt controller and its environment.
// It carries the source lines, the iack/irq handshake and the register port.
interface irq_ctl_if #(
   parameter int N_SRC = 8
);
   logic [N_SRC-1:0] src_irq;
   logic             iack;
   logic             irq;
   logic             reg_wr;
   logic             reg_rd;
   logic [1:0]       reg_addr;
   logic [31:0]      reg_wdata;
   logic [31:0]      reg_rdata;

   modport master (
      output src_irq, iack, reg_wr, reg_rd, reg_addr, reg_wdata,
      input  irq, reg_rdata
   );

   modport slave (
      input  src_irq, iack, reg_wr, reg_rd, reg_addr, reg_wdata,
      output irq, reg_rdata
   );
endinterface

// File: rtl/irq_ctl.sv
// irq_ctl: edge-triggered interrupt controller with a mask, lowest-index priority and a register port.
// Define IRQ_SYNC_EN to pass src_irq through a two-flop synchronizer before edge detection.
module irq_ctl #(
   parameter int N_SRC = 8,
   parameter int ID_W  = 3
) (
   input logic      clk,
   input logic      rst,
   irq_ctl_if.slave bus
);
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] REQ  = 2'b01;
   localparam logic [1:0] SERV = 2'b10;

   logic [N_SRC-1:0] r_src_d, r_pending, r_mask;
   logic [N_SRC-1:0] w_src, w_edge, w_w1c, w_swt, w_masked, w_win_oh, w_take_clr, w_wdata;
   logic [ID_W-1:0]  r_active_id, w_win_id;
   logic             r_active_vld, r_iack_d;
   logic             w_req, w_iack_rise, w_iack_fall, w_take, w_unused_wdata;
   logic [1:0]       r_state, w_state_nxt;
   logic [31:0]      r_rdata, w_rdata;

`ifdef IRQ_SYNC_EN
   logic [N_SRC-1:0] r_sync1, r_sync2;

   // Two-flop synchronizer so sources may be asynchronous to clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= {N_SRC{1'b0}};
         r_sync2 <= {N_SRC{1'b0}};
      end else begin
         r_sync1 <= bus.src_irq;
         r_sync2 <= r_sync1;
      end
   end
   assign w_src = r_sync2;
`else
   assign w_src = bus.src_irq;
`endif

   assign w_wdata        = bus.reg_wdata[N_SRC-1:0];
   assign w_unused_wdata = ^bus.reg_wdata;
   assign w_edge         = w_src & ~r_src_d;
   assign w_w1c          = (bus.reg_wr && bus.reg_addr == 2'd0) ? w_wdata : {N_SRC{1'b0}};
   assign w_swt          = (bus.reg_wr && bus.reg_addr == 2'd3) ? w_wdata : {N_SRC{1'b0}};
   assign w_masked       = r_pending & r_mask;
   assign w_req          = |w_masked;
   assign w_win_oh       = w_masked & (~w_masked + N_SRC'(1));
   assign w_iack_rise    = bus.iack & ~r_iack_d;
   assign w_iack_fall    = ~bus.iack & r_iack_d;
   assign w_take         = w_iack_rise && (r_state != SERV);
   assign w_take_clr     = w_take ? w_win_oh : {N_SRC{1'b0}};

   // Encode the lowest-index enabled pending source (scan high to low, last hit wins).
   always_comb begin
      w_win_id = {ID_W{1'b0}};
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (w_masked[i]) w_win_id = ID_W'(i);
         else             w_win_id = w_win_id;
      end
   end

   // Next-state logic; an acknowledge rise always takes precedence over a new request.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_iack_rise) w_state_nxt = SERV; else if (w_req)  w_state_nxt = REQ;  else w_state_nxt = IDLE;
         REQ:     if (w_iack_rise) w_state_nxt = SERV; else if (!w_req) w_state_nxt = IDLE; else w_state_nxt = REQ;
         SERV:    if (w_iack_fall) w_state_nxt = IDLE; else w_state_nxt = SERV;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Read mux; the registered copy below gives read-before-write semantics.
   always_comb begin
      w_rdata = 32'd0;
      case (bus.reg_addr)
         2'd0:    w_rdata = 32'(r_pending);
         2'd1:    w_rdata = 32'(r_mask);
         2'd2: begin
            w_rdata     = 32'(r_active_id);
            w_rdata[31] = r_active_vld;
         end
         default: w_rdata = 32'd0;
      endcase
   end

   // State, edge-detect history and pending/mask registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_src_d   <= {N_SRC{1'b0}};
         r_iack_d  <= 1'b0;
         r_pending <= {N_SRC{1'b0}};
         r_mask    <= {N_SRC{1'b0}};
      end else begin
         r_state   <= w_state_nxt;
         r_src_d   <= w_src;
         r_iack_d  <= bus.iack;
         r_pending <= (r_pending & ~w_w1c & ~w_take_clr) | w_edge | w_swt;
         if (bus.reg_wr && bus.reg_addr == 2'd1) r_mask <= w_wdata;
         else                                    r_mask <= r_mask;
      end
   end

   // Active source capture on acknowledge; a spurious ack records no valid source.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_active_vld <= 1'b0;
         r_active_id  <= {ID_W{1'b0}};
      end else if (w_take) begin
         r_active_vld <= w_req;
         r_active_id  <= w_req ? w_win_id : {ID_W{1'b0}};
      end else if (r_state == SERV && w_iack_fall) begin
         r_active_vld <= 1'b0;
      end else begin
         r_active_vld <= r_active_vld;
      end
   end

   // Read data register, updated only by a read strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             r_rdata <= 32'd0;
      else if (bus.reg_rd) r_rdata <= w_rdata;
      else                 r_rdata <= r_rdata;
   end

   assign bus.irq       = (r_state == REQ);
   assign bus.reg_rdata = r_rdata;
endmodule

// File: tb/tb_irq_ctl.sv
// tb_irq_ctl: directed self-checking bench for irq_ctl.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_irq_ctl;
`ifdef IRQ_SYNC_EN
   localparam int SRC_LAT = 4;
`else
   localparam int SRC_LAT = 2;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   irq_ctl_if #(.N_SRC(8)) bus();

   irq_ctl #(.N_SRC(8), .ID_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.reg_wr    = 1'b1;
      bus.reg_addr  = a;
      bus.reg_wdata = d;
      tick(1);
      bus.reg_wr    = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
      bus.reg_rd   = 1'b1;
      bus.reg_addr = a;
      tick(1);
      bus.reg_rd   = 1'b0;
      chk(tag, bus.reg_rdata, exp);
   endtask

   initial begin
      bus.src_irq   = 8'h00;
      bus.iack      = 1'b0;
      bus.reg_wr    = 1'b0;
      bus.reg_rd    = 1'b0;
      bus.reg_addr  = 2'd0;
      bus.reg_wdata = 32'd0;

      // Reset state
      tick(2);
      chk("rst_irq", {31'd0, bus.irq}, 32'd0);
      chk("rst_rdata", bus.reg_rdata, 32'd0);
      rst = 1'b0;
      tick(1);
      rd(2'd0, "rst_pending", 32'd0);
      rd(2'd1, "rst_mask", 32'd0);
      rd(2'd2, "rst_active", 32'd0);

      // Single source
      wr(2'd1, 32'h0000_0001);
      bus.src_irq = 8'h01;
      tick(SRC_LAT - 1);
      chk("single_irq_early", {31'd0, bus.irq}, 32'd0);
      tick(1);
      chk("single_irq_high", {31'd0, bus.irq}, 32'd1);
      bus.src_irq = 8'h00;
      bus.iack = 1'b1;
      tick(1);
      chk("single_ack_irq_low", {31'd0, bus.irq}, 32'd0);
      rd(2'd2, "single_active", 32'h8000_0000);
      rd(2'd0, "single_pending", 32'h0000_0000);
      bus.iack = 1'b0;
      tick(2);
      rd(2'd2, "single_active_ret", 32'h0000_0000);

      // Priority: sources 5 and 2 together
      wr(2'd1, 32'h0000_00FF);
      bus.src_irq = 8'h24;
      tick(SRC_LAT);
      chk("prio_irq_high", {31'd0, bus.irq}, 32'd1);
      bus.src_irq = 8'h00;
      bus.iack = 1'b1;
      tick(1);
      chk("prio_ack_irq_low", {31'd0, bus.irq}, 32'd0);
      rd(2'd2, "prio_active_2", 32'h8000_0002);
      rd(2'd0, "prio_pending_20", 32'h0000_0020);
      bus.iack = 1'b0;
      tick(1);
      chk("prio_ret_irq_low", {31'd0, bus.irq}, 32'd0);
      tick(1);
      chk("prio_rereq_irq", {31'd0, bus.irq}, 32'd1);
      bus.iack = 1'b1;
      tick(1);
      rd(2'd2, "prio_active_5", 32'h8000_0005);
      rd(2'd0, "prio_pending_0", 32'h0000_0000);
      bus.iack = 1'b0;
      tick(2);
      chk("prio_done_irq", {31'd0, bus.irq}, 32'd0);
      rd(2'd2, "active_keeps_id", 32'h0000_0005);
      wr(2'd2, 32'hFFFF_FFFF);
      rd(2'd2, "active_wr_ignored", 32'h0000_0005);

      // Masking; upper write bits are dropped
      wr(2'd1, 32'hFFFF_FF00);
      rd(2'd1, "mask_upper_ignored", 32'h0000_0000);
      bus.src_irq = 8'h08;
      tick(SRC_LAT + 1);
      chk("masked_irq_low", {31'd0, bus.irq}, 32'd0);
      bus.src_irq = 8'h00;
      tick(2);
      rd(2'd0, "masked_pending", 32'h0000_0008);
      wr(2'd1, 32'h0000_0008);
      chk("unmask_same_edge", {31'd0, bus.irq}, 32'd0);
      tick(1);
      chk("unmask_irq_high", {31'd0, bus.irq}, 32'd1);
      wr(2'd0, 32'h0000_0008);
      tick(1);
      chk("w1c_drops_req", {31'd0, bus.irq}, 32'd0);
      rd(2'd0, "w1c_pending", 32'h0000_0000);

      // Simultaneous W1C and edge on bit 1
      bus.src_irq = 8'h02;
      tick(SRC_LAT - 2);
      wr(2'd0, 32'h0000_0002);
      bus.src_irq = 8'h00;
      rd(2'd0, "set_beats_clr", 32'h0000_0002);
      wr(2'd0, 32'h0000_0002);
      rd(2'd0, "clr_alone", 32'h0000_0000);

      // Read during write returns the old MASK
      bus.reg_wr    = 1'b1;
      bus.reg_rd    = 1'b1;
      bus.reg_addr  = 2'd1;
      bus.reg_wdata = 32'h0000_0080;
      tick(1);
      bus.reg_wr = 1'b0;
      bus.reg_rd = 1'b0;
      chk("rdw_old_value", bus.reg_rdata, 32'h0000_0008);

      // SWTRIG
      wr(2'd3, 32'h0000_0080);
      chk("swtrig_irq_early", {31'd0, bus.irq}, 32'd0);
      tick(1);
      chk("swtrig_irq_high", {31'd0, bus.irq}, 32'd1);
      rd(2'd3, "swtrig_read_zero", 32'h0000_0000);
      bus.iack = 1'b1;
      tick(1);
      chk("swtrig_ack_irq", {31'd0, bus.irq}, 32'd0);
      rd(2'd2, "swtrig_active_7", 32'h8000_0007);
      bus.iack = 1'b0;
      tick(2);
      chk("swtrig_done_irq", {31'd0, bus.irq}, 32'd0);

      // Spurious acknowledge with everything masked
      wr(2'd1, 32'h0000_0000);
      wr(2'd3, 32'h0000_0001);
      tick(1);
      chk("spur_pre_irq", {31'd0, bus.irq}, 32'd0);
      bus.iack = 1'b1;
      tick(1);
      chk("spur_irq", {31'd0, bus.irq}, 32'd0);
      rd(2'd2, "spur_active_zero", 32'h0000_0000);
      rd(2'd0, "spur_pending_kept", 32'h0000_0001);
      bus.iack = 1'b0;
      tick(1);
      wr(2'd1, 32'h0000_0001);
      tick(1);
      chk("spur_back_idle_req", {31'd0, bus.irq}, 32'd1);

      // Asynchronous reset while requesting
      #2 rst = 1'b1;
      #1;
      chk("async_rst_irq", {31'd0, bus.irq}, 32'd0);
      chk("async_rst_rdata", bus.reg_rdata, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      tick(2);
      chk("post_rst_irq_a", {31'd0, bus.irq}, 32'd0);

      // Asynchronous reset while in service with pending 0x11
      wr(2'd1, 32'h0000_0011);
      wr(2'd3, 32'h0000_0011);
      tick(1);
      chk("serv_setup_irq", {31'd0, bus.irq}, 32'd1);
      bus.iack = 1'b1;
      tick(1);
      wr(2'd3, 32'h0000_0001);
      rd(2'd0, "serv_pending_11", 32'h0000_0011);
      rd(2'd2, "serv_active_0", 32'h8000_0000);
      #2 rst = 1'b1;
      #1;
      chk("serv_rst_irq", {31'd0, bus.irq}, 32'd0);
      chk("serv_rst_pending", 32'(dut.r_pending), 32'd0);
      chk("serv_rst_mask", 32'(dut.r_mask), 32'd0);
      chk("serv_rst_active", {31'd0, dut.r_active_vld}, 32'd0);
      chk("serv_rst_rdata", bus.reg_rdata, 32'd0);
      bus.iack = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      tick(3);
      chk("post_rst_irq_b", {31'd0, bus.irq}, 32'd0);
      rd(2'd0, "post_rst_pending", 32'd0);
      rd(2'd1, "post_rst_mask", 32'd0);
      rd(2'd2, "post_rst_active", 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/irq_ctl.md
# irq_ctl

Interrupt controller directly upstream of the pipeline control FSM. Collects up to N_SRC edge-triggered interrupt sources, applies a software mask, and presents a single `irq` request to the control FSM. It latches the winning source ID when the FSM acknowledges with `iack`, and holds that ID until the FSM returns from the handler, signalled by `iack` falling. Software reads and writes pending, mask and active-ID state through a small register port.

## Interface
Parameters:
- N_SRC, 8, number of interrupt sources; legal range 2..32
- ID_W, 3, width of source ID; must satisfy 2**ID_W >= N_SRC

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- src_irq  in  N_SRC  interrupt source lines; a 0->1 edge requests service
- iack  in  1  acknowledge level from the control FSM; high from IRQ entry until RET
- irq  out  1  interrupt request to the control FSM
- reg_wr  in  1  register write strobe, one cycle
- reg_rd  in  1  register read strobe, one cycle
- reg_addr  in  2  register select
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data, registered

## Operation
- Reset values: pending=0, mask=0, src_d=0, iack_d=0, state=IDLE, active_vld=0, active_id=0, irq=0, reg_rdata=0.
- Edge detect: at each clock edge, pending[i] is set when src_irq[i]=1 and src_d[i]=0. src_d holds the previous sample.
- Registers:
  - addr 0 PENDING: read returns pending, zero-extended. Write is write-1-to-clear.
  - addr 1 MASK: read/write, low N_SRC bits; 1 = enabled.
  - addr 2 ACTIVE: read returns {active_vld at bit 31, active_id at bits ID_W-1:0}. Writes are ignored.
  - addr 3 SWTRIG: write-1 sets the corresponding pending bits. Read returns 0.
- Bits of reg_wdata at or above N_SRC are ignored. Unused read bits are 0.
- Pending set/clear priority in one cycle: a hardware edge or SWTRIG set beats a W1C clear on the same bit.
- req = |(pending & mask).
- Priority: lowest index among (pending & mask) wins.
- State machine, tracking iack_d (iack registered one cycle):
  - IDLE: irq=0. Goes to REQ when req=1. Goes to SERV on an iack rising edge (iack=1, iack_d=0).
  - REQ: irq=1. Goes to SERV on an iack rise. Goes back to IDLE if req drops to 0 before iack (mask cleared or W1C).
  - SERV: irq=0. Goes to IDLE on an iack fall (iack=0, iack_d=1).
- On the iack-rise transition:
  - active_id <= winning ID and active_vld <= 1.
  - The winner's pending bit is cleared in the same cycle, unless a new edge on that source sets it in that cycle.
  - If req=0 at this point (spurious acknowledge, e.g. iack rising in IDLE): active_vld <= 0, active_id <= 0, and state still goes to SERV.
- On the SERV->IDLE transition: active_vld <= 0. active_id keeps its last value.
- Edges arriving during SERV accumulate in pending. They are requested after return; there is no nesting.
- Mask changes during SERV do not affect the active ID.

## Timing
- irq is decoded from the state register; it is glitch-free with no combinational input path.
- Source edge to irq, without IRQ_SYNC_EN: src rises before edge E0, pending is set at E0, state is REQ at E1, so irq is high after E1 (2 edges).
- iack rise to irq low: 1 edge. State leaves REQ on the edge where the sampled iack=1 and iack_d=0.
- After iack falls, the earliest re-request is irq high 1 edge after the SERV->IDLE edge, if req=1.
- Register write takes effect at the strobe edge.
- Read: reg_rdata is valid the cycle after reg_rd and holds until the next reg_rd. Read-during-write returns the pre-write value.
- reset asserted mid-operation clears all state immediately, without waiting for a clock. irq drops asynchronously.

## Configuration
- IRQ_SYNC_EN defined:
  - src_irq passes through a two-flop synchronizer, reset to 0, before edge detection.
  - Source-to-irq latency becomes 4 edges.
  - Sources may be asynchronous.
- IRQ_SYNC_EN undefined:
  - src_irq feeds edge detection directly.
  - Sources must be synchronous to clk.

## Test plan
- Single source: MASK=0x01, pulse src_irq[0] -> irq high 2 edges later (4 with IRQ_SYNC_EN). Raise iack -> irq low next edge, ACTIVE reads 0x8000_0000, PENDING reads 0x00.
- Priority: MASK=0xFF, rise src 5 and src 2 in the same cycle, ack -> ACTIVE id=2, PENDING=0x20. After iack falls, irq returns and the next ack gives id=5.
- Masking: MASK=0x00, edge on src 3 -> irq stays 0, PENDING=0x08. Write MASK=0x08 -> irq high 1 edge later. Then write PENDING W1C 0x08 while in REQ -> back to IDLE, irq=0.
- Simultaneous: W1C of bit 1 on the same edge as a src 1 rise -> PENDING bit 1 stays 1.
- SWTRIG: write 0x80 with MASK=0x80 -> irq high. Spurious iack rise with MASK=0 -> ACTIVE reads 0, state SERV, iack fall -> IDLE.
- Reset asserted while in SERV with pending=0x11 -> irq, pending, mask and active all 0 without a clock edge. After reset is released, irq stays low.
